sdr_ch3_arbiter: RTL and testbench
==================================

SDR_CH3_ARBITER -- requirements
Module: sdr_ch3_arbiter

Interface
REQ-001 Parameter AW, default 25: byte-address width of every address port.
REQ-002 Parameter STARVE_MAX, default 8: consecutive BG2 grants allowed while NV waits before NV is forced.
REQ-003 Parameter TIMEOUT, default 255: maximum WAIT cycles before a transaction is abandoned.
REQ-004 clk  in  1  single clock (SDR_CLK domain); all logic is on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 download  in  1  ROM download in progress; enables the ROM requester.
REQ-007 rom_addr/rom_din/rom_be/rom_req  in  AW/16/2/1  ROM loader write request; rom_req held high until rom_rdy.
REQ-008 rom_rdy  out  1  one-cycle ROM write completion pulse.
REQ-009 bg2_addr/bg2_req  in  AW/1  BG2 tile read request; bg2_req held high until bg2_rdy.
REQ-010 bg2_dout/bg2_rdy  out  16/1  BG2 read data (registered) and one-cycle completion pulse.
REQ-011 nv_addr/nv_din/nv_be/nv_rnw/nv_req  in  AW/16/2/1/1  NVRAM/hiscore request, read when nv_rnw=1; nv_req held high until nv_rdy.
REQ-012 nv_dout/nv_rdy  out  16/1  NV read data (registered) and one-cycle completion pulse.
REQ-013 ch_addr/ch_din/ch_be/ch_rnw  out  AW/16/2/1  SDRAM channel-3 command fields, registered.
REQ-014 ch_req  out  1  toggle: each transition issues one channel command.
REQ-015 ch_dout/ch_ready  in  16/1  channel read data, valid in the cycle ch_ready pulses high.
REQ-016 timeout_err  out  1  sticky; set on any abandoned transaction.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT, DONE.
REQ-018 IDLE: when any eligible request is high, select the grantee, latch its fields into ch_*, latch the grantee ID, then go to ISSUE the next cycle.
REQ-019 Eligibility: the ROM requester is eligible only while download=1; BG2 and NV are eligible only while download=0.
REQ-020 Priority: ROM first, then BG2, then NV. When starve_cnt=STARVE_MAX and nv_req=1, NV wins over BG2.
REQ-021 starve_cnt:
- increments on each BG2 grant while nv_req=1;
- clears on any NV grant and whenever nv_req=0;
- saturates at STARVE_MAX.
REQ-022 ISSUE: toggle ch_req exactly once, clear the timeout counter, and go to WAIT.
REQ-023 ch_addr, ch_din, ch_be and ch_rnw stay constant from ISSUE until the exit from WAIT.
REQ-024 ch_rnw per grantee: forced to 0 for ROM, 1 for BG2, nv_rnw for NV.
REQ-025 WAIT: on ch_ready=1, capture ch_dout into the grantee's dout register (read grants only) and go to DONE.
REQ-026 DONE: pulse the grantee's rdy for exactly one cycle, then return to IDLE.
REQ-027 Latency: grant cycle to ISSUE is 1 cycle; ch_ready to the rdy pulse is 1 cycle.
REQ-028 Back-to-back throughput: IDLE is visited once per transaction, so the minimum spacing between transactions is 4 cycles plus the channel latency.
REQ-029 Timeout counter: 8 bits, increments each WAIT cycle. When it reaches TIMEOUT with no ch_ready:
- set timeout_err;
- go to DONE;
- pulse the grantee's rdy with its dout unchanged.
REQ-030 A ch_ready arriving outside WAIT is ignored and does not disturb state or outputs.
REQ-031 Requests whose req drops before their grant are not serviced. A req that drops after the grant has no effect; the transaction completes.
REQ-032 A download change mid-transaction does not abort it; eligibility is re-evaluated only in IDLE.
REQ-033 The non-granted rdy outputs stay 0 at all times.
REQ-034 Only one rdy output is high in any cycle.

Reset
REQ-035 Reset forces:
- state to IDLE;
- ch_req, ch_addr, ch_din, ch_be, rom_rdy, bg2_rdy, nv_rdy, timeout_err, starve_cnt and the timeout counter to 0;
- ch_rnw to 1;
- bg2_dout and nv_dout to 16'h0000.
REQ-036 Reset asserted mid-transaction abandons it without a rdy pulse. After reset, the first ch_req toggle goes 0->1.

Verification
REQ-037 download=1, rom_req with addr=25'h000100, din=16'hA55A, be=2'b11; channel ready after 5 cycles -> ch_rnw=0, ch_addr=25'h000100, exactly one ch_req toggle, and a single rom_rdy pulse 1 cycle after ch_ready.
REQ-038 download=0, bg2_req and nv_req (read) both high in the same cycle; channel returns 16'h1234 -> BG2 is granted first with bg2_dout=16'h1234, then NV.
REQ-039 Starvation: bg2_req held continuously and nv_req high -> NV is granted after exactly 8 BG2 grants, then starve_cnt=0.
REQ-040 Timeout: the channel never asserts ch_ready -> after 255 WAIT cycles the grantee's rdy pulses, timeout_err=1 and stays 1, and the FSM returns to IDLE.
REQ-041 Reset asserted during WAIT of a BG2 read -> no bg2_rdy pulse, all outputs at their reset values, and the next grant toggles ch_req to 1.
REQ-042 Spurious ch_ready in IDLE, and download=1 with only bg2_req high -> no state change and no rdy pulse.

Source files
------------

// File: rtl/sdr_ch3_arbiter_if.sv
// sdr_ch3_arbiter_if: requester handshakes and SDRAM channel-3 command/response signals
interface sdr_ch3_arbiter_if #(
   parameter int AW = 25
);
   logic          download;
   logic [AW-1:0] rom_addr;
   logic [15:0]   rom_din;
   logic [1:0]    rom_be;
   logic          rom_req;
   logic          rom_rdy;
   logic [AW-1:0] bg2_addr;
   logic          bg2_req;
   logic [15:0]   bg2_dout;
   logic          bg2_rdy;
   logic [AW-1:0] nv_addr;
   logic [15:0]   nv_din;
   logic [1:0]    nv_be;
   logic          nv_rnw;
   logic          nv_req;
   logic [15:0]   nv_dout;
   logic          nv_rdy;
   logic [AW-1:0] ch_addr;
   logic [15:0]   ch_din;
   logic [1:0]    ch_be;
   logic          ch_rnw;
   logic          ch_req;
   logic [15:0]   ch_dout;
   logic          ch_ready;
   logic          timeout_err;
   modport master (
      input  download, rom_addr, rom_din, rom_be, rom_req, bg2_addr, bg2_req,
             nv_addr, nv_din, nv_be, nv_rnw, nv_req, ch_dout, ch_ready,
      output rom_rdy, bg2_dout, bg2_rdy, nv_dout, nv_rdy,
             ch_addr, ch_din, ch_be, ch_rnw, ch_req, timeout_err
   );
   modport slave (
      output download, rom_addr, rom_din, rom_be, rom_req, bg2_addr, bg2_req,
             nv_addr, nv_din, nv_be, nv_rnw, nv_req, ch_dout, ch_ready,
      input  rom_rdy, bg2_dout, bg2_rdy, nv_dout, nv_rdy,
             ch_addr, ch_din, ch_be, ch_rnw, ch_req, timeout_err
   );
endinterface

// File: rtl/sdr_ch3_arbiter.sv
// sdr_ch3_arbiter: arbitrates ROM loader, BG2 tile reads and NVRAM onto SDRAM channel 3
module sdr_ch3_arbiter #(
   parameter int AW         = 25,
   parameter int STARVE_MAX = 8,
   parameter int TIMEOUT    = 255
) (
   input logic               clk,
   input logic               reset,
   sdr_ch3_arbiter_if.master bus
);
   localparam int            SW       = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] S_MAX    = SW'(STARVE_MAX);
   localparam logic [7:0]    TMO_LAST = 8'(TIMEOUT - 1);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
   typedef enum logic [1:0] {G_ROM, G_BG2, G_NV} gnt_t;
   state_t        state_q, state_d;
   gnt_t          gnt_q, gnt_d;
   logic [AW-1:0] ch_addr_q, ch_addr_d;
   logic [15:0]   ch_din_q, ch_din_d;
   logic [1:0]    ch_be_q, ch_be_d;
   logic          ch_rnw_q, ch_rnw_d;
   logic          ch_req_q, ch_req_d;
   logic [15:0]   bg2_dout_q, bg2_dout_d;
   logic [15:0]   nv_dout_q, nv_dout_d;
   logic          rom_rdy_q, rom_rdy_d;
   logic          bg2_rdy_q, bg2_rdy_d;
   logic          nv_rdy_q, nv_rdy_d;
   logic          timeout_err_q, timeout_err_d;
   logic [SW-1:0] starve_q, starve_d;
   logic [7:0]    tmo_q, tmo_d;
   logic          done_now, nv_force, rom_g, bg2_g, nv_g;
   assign nv_force  = bus.nv_req && starve_q == S_MAX;
   assign rom_g     = bus.download && bus.rom_req;
   assign bg2_g     = !bus.download && bus.bg2_req && !nv_force;
   assign nv_g      = !bus.download && bus.nv_req && (nv_force || !bus.bg2_req);
   assign rom_rdy_d = done_now && gnt_q == G_ROM;
   assign bg2_rdy_d = done_now && gnt_q == G_BG2;
   assign nv_rdy_d  = done_now && gnt_q == G_NV;
   // Grant selection in IDLE, one command toggle in ISSUE, completion or timeout in WAIT
   always_comb begin
      state_d       = state_q;
      gnt_d         = gnt_q;
      ch_addr_d     = ch_addr_q;
      ch_din_d      = ch_din_q;
      ch_be_d       = ch_be_q;
      ch_rnw_d      = ch_rnw_q;
      ch_req_d      = ch_req_q;
      bg2_dout_d    = bg2_dout_q;
      nv_dout_d     = nv_dout_q;
      timeout_err_d = timeout_err_q;
      tmo_d         = tmo_q;
      starve_d      = bus.nv_req ? starve_q : '0;
      done_now      = 1'b0;
      case (state_q)
         IDLE: begin
            if (rom_g) begin
               state_d   = ISSUE;
               gnt_d     = G_ROM;
               ch_addr_d = bus.rom_addr;
               ch_din_d  = bus.rom_din;
               ch_be_d   = bus.rom_be;
               ch_rnw_d  = 1'b0;
            end else if (bg2_g) begin
               state_d   = ISSUE;
               gnt_d     = G_BG2;
               ch_addr_d = bus.bg2_addr;
               ch_din_d  = '0;
               ch_be_d   = 2'b11;
               ch_rnw_d  = 1'b1;
               if (bus.nv_req && starve_q != S_MAX) starve_d = starve_q + SW'(1);
            end else if (nv_g) begin
               state_d   = ISSUE;
               gnt_d     = G_NV;
               ch_addr_d = bus.nv_addr;
               ch_din_d  = bus.nv_din;
               ch_be_d   = bus.nv_be;
               ch_rnw_d  = bus.nv_rnw;
               starve_d  = '0;
            end
         end
         ISSUE: begin
            ch_req_d = ~ch_req_q;
            tmo_d    = '0;
            state_d  = WAIT;
         end
         WAIT: begin
            tmo_d = tmo_q + 8'd1;
            if (bus.ch_ready) begin
               state_d    = DONE;
               done_now   = 1'b1;
               bg2_dout_d = gnt_q == G_BG2 ? bus.ch_dout : bg2_dout_q;
               nv_dout_d  = (gnt_q == G_NV && ch_rnw_q) ? bus.ch_dout : nv_dout_q;
            end else if (tmo_q == TMO_LAST) begin
               state_d       = DONE;
               done_now      = 1'b1;
               timeout_err_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         gnt_q         <= G_ROM;
         ch_addr_q     <= '0;
         ch_din_q      <= '0;
         ch_be_q       <= '0;
         ch_rnw_q      <= 1'b1;
         ch_req_q      <= 1'b0;
         bg2_dout_q    <= 16'h0000;
         nv_dout_q     <= 16'h0000;
         rom_rdy_q     <= 1'b0;
         bg2_rdy_q     <= 1'b0;
         nv_rdy_q      <= 1'b0;
         timeout_err_q <= 1'b0;
         starve_q      <= '0;
         tmo_q         <= '0;
      end else begin
         state_q       <= state_d;
         gnt_q         <= gnt_d;
         ch_addr_q     <= ch_addr_d;
         ch_din_q      <= ch_din_d;
         ch_be_q       <= ch_be_d;
         ch_rnw_q      <= ch_rnw_d;
         ch_req_q      <= ch_req_d;
         bg2_dout_q    <= bg2_dout_d;
         nv_dout_q     <= nv_dout_d;
         rom_rdy_q     <= rom_rdy_d;
         bg2_rdy_q     <= bg2_rdy_d;
         nv_rdy_q      <= nv_rdy_d;
         timeout_err_q <= timeout_err_d;
         starve_q      <= starve_d;
         tmo_q         <= tmo_d;
      end
   end
   assign bus.ch_addr     = ch_addr_q;
   assign bus.ch_din      = ch_din_q;
   assign bus.ch_be       = ch_be_q;
   assign bus.ch_rnw      = ch_rnw_q;
   assign bus.ch_req      = ch_req_q;
   assign bus.bg2_dout    = bg2_dout_q;
   assign bus.nv_dout     = nv_dout_q;
   assign bus.rom_rdy     = rom_rdy_q;
   assign bus.bg2_rdy     = bg2_rdy_q;
   assign bus.nv_rdy      = nv_rdy_q;
   assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_sdr_ch3_arbiter.sv
// tb_sdr_ch3_arbiter: directed scoreboard bench with a latency-programmable channel responder
module tb_sdr_ch3_arbiter;
   typedef struct {
      logic [2:0]  who;
      logic [15:0] data;
   } exp_t;
   logic        clk = 1'b0;
   logic        reset;
   logic        prev_req, ch_en, rsp_ready, spur_ready, last_rnw;
   logic [24:0] last_addr;
   logic [15:0] last_din, resp_data;
   int          n_tests = 0, n_fail = 0;
   int          cyc = 0, tog_cnt = 0, cd = -1, lat = 0;
   int          tog_cyc = 0, ready_cyc = 0, rdy_cyc = 0;
   exp_t        sb[$];
   sdr_ch3_arbiter_if #(.AW(25)) bus ();
   sdr_ch3_arbiter dut (.clk(clk), .reset(reset), .bus(bus));
   assign bus.ch_ready = rsp_ready | spur_ready;
   always #5 clk = ~clk;
   // Cycle counter used for latency measurements
   always @(posedge clk) cyc <= cyc + 1;
   // Channel model: counts ch_req toggles and answers after lat cycles when enabled
   initial begin
      prev_req    = 1'b0;
      rsp_ready   = 1'b0;
      bus.ch_dout = 16'h0000;
      last_addr   = '0;
      last_din    = '0;
      last_rnw    = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         rsp_ready = 1'b0;
         if (reset) begin
            prev_req = 1'b0;
            cd       = -1;
         end else begin
            if (bus.ch_req !== prev_req) begin
               prev_req  = bus.ch_req;
               tog_cnt++;
               tog_cyc   = cyc;
               last_addr = bus.ch_addr;
               last_din  = bus.ch_din;
               last_rnw  = bus.ch_rnw;
               cd        = ch_en ? lat : -1;
            end else if (cd > 0) cd--;
            if (cd == 0) begin
               rsp_ready   = 1'b1;
               bus.ch_dout = resp_data;
               ready_cyc   = cyc;
               cd          = -1;
            end
         end
      end
   end
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic expect_rdy(input logic [2:0] who, input logic [15:0] data);
      exp_t e;
      e.who  = who;
      e.data = data;
      sb.push_back(e);
   endtask
   task automatic wait_rdy(input string tag, input int max_cyc);
      exp_t       e;
      logic [2:0] who;
      for (int i = 0; i < max_cyc; i++) begin
         step();
         who = {bus.nv_rdy, bus.bg2_rdy, bus.rom_rdy};
         if (who != 3'b000) begin
            rdy_cyc = cyc;
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $error("FAIL %s: observed rdy %b expected none", tag, who);
               return;
            end
            e = sb.pop_front();
            chk({tag, " who"}, 32'(who), 32'(e.who));
            if (e.who == 3'b010) chk({tag, " bg2_dout"}, 32'(bus.bg2_dout), 32'(e.data));
            if (e.who == 3'b100) chk({tag, " nv_dout"}, 32'(bus.nv_dout), 32'(e.data));
            return;
         end
      end
      n_tests++;
      n_fail++;
      $error("FAIL %s: observed no rdy within %0d cycles expected a rdy pulse", tag, max_cyc);
   endtask
   task automatic chk_reset(input string tag);
      chk({tag, " ch_req"}, 32'(bus.ch_req), 32'd0);
      chk({tag, " ch_rnw"}, 32'(bus.ch_rnw), 32'd1);
      chk({tag, " ch_addr"}, 32'(bus.ch_addr), 32'd0);
      chk({tag, " ch_din/be"}, 32'({bus.ch_din, bus.ch_be}), 32'd0);
      chk({tag, " rdys"}, 32'({bus.nv_rdy, bus.bg2_rdy, bus.rom_rdy}), 32'd0);
      chk({tag, " timeout_err"}, 32'(bus.timeout_err), 32'd0);
      chk({tag, " douts"}, {bus.bg2_dout, bus.nv_dout}, 32'd0);
   endtask
   initial begin
      int t0;
      reset = 1'b1;
      ch_en = 1'b1;
      spur_ready = 1'b0;
      resp_data = 16'h0000;
      bus.download = 1'b0;
      bus.rom_addr = '0;
      bus.rom_din = '0;
      bus.rom_be = '0;
      bus.rom_req = 1'b0;
      bus.bg2_addr = '0;
      bus.bg2_req = 1'b0;
      bus.nv_addr = '0;
      bus.nv_din = '0;
      bus.nv_be = '0;
      bus.nv_rnw = 1'b1;
      bus.nv_req = 1'b0;
      repeat (3) step();
      chk_reset("reset");
      reset = 1'b0;
      step();
      // ROM write during download
      bus.download = 1'b1;
      bus.rom_addr = 25'h000100;
      bus.rom_din = 16'hA55A;
      bus.rom_be = 2'b11;
      bus.rom_req = 1'b1;
      lat = 5;
      expect_rdy(3'b001, 16'h0000);
      wait_rdy("rom", 50);
      bus.rom_req = 1'b0;
      chk("rom toggles", 32'(tog_cnt), 32'd1);
      chk("rom ch_rnw", 32'(last_rnw), 32'd0);
      chk("rom ch_addr", 32'(last_addr), 32'h000100);
      chk("rom ch_din", 32'(last_din), 32'hA55A);
      chk("rom ready->rdy", 32'(rdy_cyc - ready_cyc), 32'd1);
      chk("rom ch_req level", 32'(bus.ch_req), 32'd1);
      step();
      chk("rom single pulse", 32'(bus.rom_rdy), 32'd0);
      repeat (3) step();
      chk("rom no reissue", 32'(tog_cnt), 32'd1);
      // BG2 and NV read requested together: BG2 first
      bus.download = 1'b0;
      bus.bg2_addr = 25'h000200;
      bus.nv_addr = 25'h000300;
      bus.nv_rnw = 1'b1;
      bus.bg2_req = 1'b1;
      bus.nv_req = 1'b1;
      lat = 2;
      resp_data = 16'h1234;
      expect_rdy(3'b010, 16'h1234);
      expect_rdy(3'b100, 16'h5678);
      wait_rdy("pri bg2", 50);
      bus.bg2_req = 1'b0;
      resp_data = 16'h5678;
      chk("pri bg2 addr", 32'(last_addr), 32'h000200);
      chk("pri bg2 rnw", 32'(last_rnw), 32'd1);
      wait_rdy("pri nv", 50);
      bus.nv_req = 1'b0;
      chk("pri nv addr", 32'(last_addr), 32'h000300);
      chk("pri bg2_dout kept", 32'(bus.bg2_dout), 32'h1234);
      // Starvation: NV write forced after eight BG2 grants
      bus.bg2_addr = 25'h000400;
      bus.nv_addr = 25'h000480;
      bus.nv_din = 16'hCAFE;
      bus.nv_be = 2'b01;
      bus.nv_rnw = 1'b0;
      bus.bg2_req = 1'b1;
      bus.nv_req = 1'b1;
      lat = 0;
      resp_data = 16'hBEEF;
      for (int i = 0; i < 8; i++) expect_rdy(3'b010, 16'hBEEF);
      expect_rdy(3'b100, 16'h5678);
      for (int i = 0; i < 9; i++) wait_rdy("starve", 40);
      bus.bg2_req = 1'b0;
      bus.nv_req = 1'b0;
      chk("starve nv rnw", 32'(last_rnw), 32'd0);
      chk("starve nv din", 32'(last_din), 32'hCAFE);
      chk("starve cnt clear", 32'(dut.starve_q), 32'd0);
      // Timeout: channel never answers
      step();
      ch_en = 1'b0;
      bus.bg2_addr = 25'h000500;
      bus.bg2_req = 1'b1;
      expect_rdy(3'b010, 16'hBEEF);
      wait_rdy("timeout", 400);
      bus.bg2_req = 1'b0;
      chk("timeout wait cycles", 32'(rdy_cyc - tog_cyc), 32'd255);
      chk("timeout_err set", 32'(bus.timeout_err), 32'd1);
      t0 = tog_cnt;
      repeat (3) step();
      chk("timeout_err sticky", 32'(bus.timeout_err), 32'd1);
      chk("timeout idle", 32'(tog_cnt), 32'(t0));
      // Reset during a BG2 read in WAIT
      bus.bg2_addr = 25'h000600;
      bus.bg2_req = 1'b1;
      for (int i = 0; i < 10 && tog_cnt == t0; i++) step();
      chk("rst-wait issued", 32'(tog_cnt), 32'(t0 + 1));
      repeat (3) step();
      reset = 1'b1;
      bus.bg2_req = 1'b0;
      step();
      step();
      chk_reset("rst-wait");
      reset = 1'b0;
      repeat (2) step();
      chk("rst-wait no rdy", 32'({bus.nv_rdy, bus.bg2_rdy, bus.rom_rdy}), 32'd0);
      ch_en = 1'b1;
      lat = 1;
      resp_data = 16'h0F0F;
      bus.bg2_addr = 25'h000700;
      bus.bg2_req = 1'b1;
      expect_rdy(3'b010, 16'h0F0F);
      wait_rdy("post-rst", 50);
      bus.bg2_req = 1'b0;
      chk("post-rst ch_req", 32'(bus.ch_req), 32'd1);
      chk("post-rst addr", 32'(last_addr), 32'h000700);
      // Spurious ch_ready in IDLE, then BG2 request while downloading
      repeat (2) step();
      t0 = tog_cnt;
      resp_data = 16'hDEAD;
      bus.ch_dout = 16'hDEAD;
      spur_ready = 1'b1;
      step();
      spur_ready = 1'b0;
      step();
      chk("spur rdys", 32'({bus.nv_rdy, bus.bg2_rdy, bus.rom_rdy}), 32'd0);
      chk("spur bg2_dout", 32'(bus.bg2_dout), 32'h0F0F);
      chk("spur ch_req", 32'(bus.ch_req), 32'd1);
      bus.download = 1'b1;
      bus.bg2_req = 1'b1;
      repeat (6) step();
      chk("dl bg2 no issue", 32'(tog_cnt), 32'(t0));
      chk("dl bg2 no rdy", 32'({bus.nv_rdy, bus.bg2_rdy, bus.rom_rdy}), 32'd0);
      bus.bg2_req = 1'b0;
      bus.download = 1'b0;
      chk("scoreboard drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
